// File: rtl/lm_msg_arbiter.sv
// Round-robin collector of LED messages into a circular FIFO, released to the decoder one at a time with a minimum hold.
// Optional build macro LM_DROP_OLDEST_EN: a push into a full FIFO overwrites the oldest entry and sets drop_flag.
module lm_msg_arbiter #(
   parameter int WIDTH       = 8,
   parameter int NUM_SRC     = 3,
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 12000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       fifo_empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       drop_flag
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(HOLD_CYCLES);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 2);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRC_W-1:0]   rr_q, rr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [WIDTH-1:0]   rd_data_q, rd_data_d;
   logic               fifo_empty_q, fifo_empty_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               gnt_found;
   logic [SRC_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]   push_data;
   logic               full;
   logic               can_push;
   logic               push;
   logic               pop;
   logic               overwrite;
   logic [PTR_W-1:0]   rd_next;

   assign full = (level_q == LVL_FULL);

`ifdef LM_DROP_OLDEST_EN
   logic drop_flag_q, drop_flag_d;

   assign can_push  = 1'b1;
   assign overwrite = push & full;
   assign drop_flag = drop_flag_q;

   always_comb begin
      drop_flag_d = drop_flag_q | overwrite;
   end

   always_ff @(posedge clk) begin
      if (rst) drop_flag_q <= 1'b0;
      else     drop_flag_q <= drop_flag_d;
   end
`else
   assign can_push  = ~full;
   assign overwrite = 1'b0;
   assign drop_flag = 1'b0;
`endif

   // Search from the round-robin pointer upward, then wrap to the low indices.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_q;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (!gnt_found && src_valid[j] && (SRC_W'(j) >= rr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = SRC_W'(j);
         end
      end
      for (int j = 0; j < NUM_SRC; j++) begin
         if (!gnt_found && src_valid[j] && (SRC_W'(j) < rr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = SRC_W'(j);
         end
      end
   end

   assign push = gnt_found & can_push & ~rst;

   always_comb begin
      push_data = '0;
      src_ready = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         src_ready[j] = push && (gnt_idx == SRC_W'(j));
         if (gnt_idx == SRC_W'(j)) push_data = src_data[j*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (push) rr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
   end

   assign pop     = (state_q == IDLE) && (level_q != '0);
   assign rd_next = rd_ptr_q + PTR_W'(1);

   // An overwrite retires the oldest entry, so a same-cycle pop takes the one behind it.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop) + PTR_W'(overwrite);
      if (overwrite) level_d = pop ? LVL_FULL - LVL_W'(1) : LVL_FULL;
      else           level_d = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_data_d    = rd_data_q;
      fifo_empty_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (pop) begin
               rd_data_d    = overwrite ? mem_q[rd_next] : mem_q[rd_ptr_q];
               fifo_empty_d = 1'b0;
               cnt_d        = HOLD_LOAD;
               state_d      = SHOW;
            end
         end
         SHOW: state_d = HOLD;
         HOLD: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         rd_data_q    <= '0;
         fifo_empty_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_q         <= rr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         rd_data_q    <= rd_data_d;
         fifo_empty_q <= fifo_empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign rd_data    = rd_data_q;
   assign fifo_empty = fifo_empty_q;
   assign level      = level_q;

endmodule

// File: tb/tb_lm_msg_arbiter.sv
// Directed bench for lm_msg_arbiter with WIDTH=8, NUM_SRC=3, DEPTH=4, HOLD_CYCLES=4.
module tb_lm_msg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  src_valid;
   logic [23:0] src_data;
   logic [2:0]  src_ready;
   logic [7:0]  rd_data;
   logic        fifo_empty;
   logic [2:0]  level;
   logic        drop_flag;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [7:0] pres_data[$];
   int         pres_cyc[$];

   lm_msg_arbiter #(
      .WIDTH(8), .NUM_SRC(3), .DEPTH(4), .HOLD_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .rd_data(rd_data), .fifo_empty(fifo_empty),
      .level(level), .drop_flag(drop_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fifo_empty === 1'b0) begin
         pres_data.push_back(rd_data);
         pres_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      src_valid = 3'b111;
      src_data = 24'h332211;
      #1;
      n_tests++;
      if (src_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b expected 000", src_ready); end
      step();
      step();
      n_tests++;
      if (src_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_held: got %b expected 000", src_ready); end
      src_valid = '0;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_tests++;
         if (fifo_empty !== 1'b1 || rd_data !== 8'h00 || level !== 3'd0 || src_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got empty=%b data=%h level=%0d ready=%b expected 1/00/0/000",
                     fifo_empty, rd_data, level, src_ready);
         end
         step();
      end
   endtask

   task automatic test_single();
      int e;
      pres_data.delete();
      pres_cyc.delete();
      src_valid = 3'b001;
      src_data = 24'h0000A5;
      #1;
      n_tests++;
      if (src_ready !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %b expected 001", src_ready); end
      e = cyc + 1;
      step();
      src_valid = '0;
      n_tests++;
      if (level !== 3'd1 || fifo_empty !== 1'b1) begin
         n_fail++; $display("FAIL single_after_push: got level=%0d empty=%b expected 1/1", level, fifo_empty);
      end
      step();
      n_tests++;
      if (fifo_empty !== 1'b0 || rd_data !== 8'hA5) begin
         n_fail++; $display("FAIL single_show: got empty=%b data=%h expected 0/a5", fifo_empty, rd_data);
      end
      step();
      n_tests++;
      if (fifo_empty !== 1'b1 || rd_data !== 8'hA5) begin
         n_fail++; $display("FAIL single_hold: got empty=%b data=%h expected 1/a5", fifo_empty, rd_data);
      end
      repeat (6) step();
      n_tests++;
      if (pres_data.size() !== 1) begin
         n_fail++; $display("FAIL single_count: got %0d presentations expected 1", pres_data.size());
      end else begin
         n_tests++;
         if (pres_cyc[0] !== e + 1) begin
            n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", pres_cyc[0], e + 1);
         end
      end
      n_tests++;
      if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_sticky: got %h expected a5", rd_data); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
      do_reset();
      pres_data.delete();
      pres_cyc.delete();
      src_valid = 3'b111;
      src_data = 24'h332211;
      #1;
      n_tests++;
      if (src_ready !== 3'b001) begin n_fail++; $display("FAIL rr_grant0: got %b expected 001", src_ready); end
      step();
      src_valid = 3'b110;
      #1;
      n_tests++;
      if (src_ready !== 3'b010) begin n_fail++; $display("FAIL rr_grant1: got %b expected 010", src_ready); end
      step();
      src_valid = 3'b100;
      #1;
      n_tests++;
      if (src_ready !== 3'b100) begin n_fail++; $display("FAIL rr_grant2: got %b expected 100", src_ready); end
      step();
      src_valid = '0;
      for (int c = 0; c < 60 && pres_data.size() < 3; c++) step();
      n_tests++;
      if (pres_data.size() !== 3) begin
         n_fail++; $display("FAIL rr_count: got %0d presentations expected 3", pres_data.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (pres_data[i] !== exp_d[i]) begin
               n_fail++; $display("FAIL rr_data%0d: got %h expected %h", i, pres_data[i], exp_d[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_tests++;
            if (pres_cyc[i] - pres_cyc[i-1] !== 4) begin
               n_fail++; $display("FAIL rr_spacing%0d: got %0d expected 4", i, pres_cyc[i] - pres_cyc[i-1]);
            end
         end
      end
      step();
      n_tests++;
      if (level !== 3'd0 || rd_data !== 8'h33) begin
         n_fail++; $display("FAIL rr_final: got level=%0d data=%h expected 0/33", level, rd_data);
      end
   endtask

`ifndef LM_DROP_OLDEST_EN
   task automatic test_full_stall();
      logic [7:0] msgs [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      int k = 0;
      int full_seen = 0;
      int viol = 0;
      int maxl = 0;
      logic rdy;
      do_reset();
      pres_data.delete();
      pres_cyc.delete();
      for (int c = 0; c < 40 && k < 6; c++) begin
         src_valid = 3'b010;
         src_data = {8'h00, msgs[k], 8'h00};
         #1;
         if (int'(level) > maxl) maxl = int'(level);
         if (level == 3'd4) begin
            full_seen++;
            if (src_ready[1]) viol++;
         end
         rdy = src_ready[1];
         step();
         if (rdy) k++;
      end
      src_valid = '0;
      n_tests++;
      if (k !== 6) begin n_fail++; $display("FAIL stall_accepted: got %0d expected 6", k); end
      n_tests++;
      if (maxl !== 4) begin n_fail++; $display("FAIL stall_max_level: got %0d expected 4", maxl); end
      n_tests++;
      if (full_seen !== 1) begin n_fail++; $display("FAIL stall_full_cycles: got %0d expected 1", full_seen); end
      n_tests++;
      if (viol !== 0) begin n_fail++; $display("FAIL stall_ready_when_full: got %0d expected 0", viol); end
      for (int c = 0; c < 60 && pres_data.size() < 6; c++) step();
      n_tests++;
      if (pres_data.size() !== 6) begin
         n_fail++; $display("FAIL stall_count: got %0d presentations expected 6", pres_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (pres_data[i] !== msgs[i]) begin
               n_fail++; $display("FAIL stall_data%0d: got %h expected %h", i, pres_data[i], msgs[i]);
            end
         end
      end
      n_tests++;
      if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL stall_drop_flag: got %b expected 0", drop_flag); end
   endtask
`else
   task automatic test_drop_oldest();
      logic [7:0] msgs [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      logic [7:0] exp_d [6] = '{8'hF0, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
      do_reset();
      pres_data.delete();
      pres_cyc.delete();
      src_valid = 3'b001;
      src_data = 24'h0000F0;
      step();
      src_valid = '0;
      step();
      for (int k = 0; k < 6; k++) begin
         src_valid = 3'b010;
         src_data = {8'h00, msgs[k], 8'h00};
         #1;
         n_tests++;
         if (src_ready !== 3'b010) begin n_fail++; $display("FAIL drop_grant%0d: got %b expected 010", k, src_ready); end
         if (k == 5) begin
            n_tests++;
            if (level !== 3'd4 || drop_flag !== 1'b0) begin
               n_fail++; $display("FAIL drop_pre_overwrite: got level=%0d drop=%b expected 4/0", level, drop_flag);
            end
         end
         step();
      end
      src_valid = '0;
      n_tests++;
      if (level !== 3'd4 || drop_flag !== 1'b1) begin
         n_fail++; $display("FAIL drop_post_overwrite: got level=%0d drop=%b expected 4/1", level, drop_flag);
      end
      for (int c = 0; c < 60 && pres_data.size() < 6; c++) step();
      n_tests++;
      if (pres_data.size() !== 6) begin
         n_fail++; $display("FAIL drop_count: got %0d presentations expected 6", pres_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (pres_data[i] !== exp_d[i]) begin
               n_fail++; $display("FAIL drop_data%0d: got %h expected %h", i, pres_data[i], exp_d[i]);
            end
         end
      end
      n_tests++;
      if (drop_flag !== 1'b1 || level !== 3'd0) begin
         n_fail++; $display("FAIL drop_sticky: got drop=%b level=%0d expected 1/0", drop_flag, level);
      end
   endtask
`endif

   task automatic test_reset_mid_hold();
      do_reset();
      src_valid = 3'b111;
      src_data = 24'hA3A2A1;
      step();
      src_valid = 3'b110;
      step();
      src_valid = 3'b100;
      step();
      src_valid = 3'b001;
      src_data = 24'hA3A2A4;
      step();
      src_valid = '0;
      n_tests++;
      if (level !== 3'd3) begin n_fail++; $display("FAIL rsthold_pre_level: got %0d expected 3", level); end
      rst = 1'b1;
      step();
      n_tests++;
      if (level !== 3'd0 || fifo_empty !== 1'b1 || rd_data !== 8'h00) begin
         n_fail++; $display("FAIL rsthold_after: got level=%0d empty=%b data=%h expected 0/1/00",
                            level, fifo_empty, rd_data);
      end
      rst = 1'b0;
      pres_data.delete();
      pres_cyc.delete();
      repeat (12) step();
      n_tests++;
      if (pres_data.size() !== 0) begin
         n_fail++; $display("FAIL rsthold_no_present: got %0d presentations expected 0", pres_data.size());
      end
      n_tests++;
      if (level !== 3'd0 || rd_data !== 8'h00) begin
         n_fail++; $display("FAIL rsthold_idle: got level=%0d data=%h expected 0/00", level, rd_data);
      end
   endtask

   initial begin
      rst = 1'b1;
      src_valid = '0;
      src_data = '0;
      test_reset();
      test_single();
      test_round_robin();
`ifdef LM_DROP_OLDEST_EN
      test_drop_oldest();
`else
      test_full_stall();
`endif
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
